// File: rtl/params_loader.sv
// Streams parameter words into a contiguous params address range (LOAD) or
// re-reads that range and counts stored-precision mismatches against a second stream (VERIFY).
module params_loader #(
  parameter int N_COMP       = 16,
  parameter int DATA_W       = N_COMP,
  parameter int Q_COMP       = 10,
  parameter int N_STO_PARAMS = 8,
  parameter int FMT_W        = 2,
  parameter int ADDR_W       = 5,
  parameter int BANK_WORDS   = 16,
  parameter int DEPTH        = 2 * BANK_WORDS,
  parameter int MISMATCH_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       len,
  input  logic [FMT_W-1:0]      format,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic                  wr_chip_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [FMT_W-1:0]      wr_format,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [FMT_W-1:0]      rd_format,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_range,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [FMT_W-1:0] FMT_FX_2_X = FMT_W'(0);
  localparam logic [FMT_W-1:0] FMT_FX_3_X = FMT_W'(1);
  localparam logic [FMT_W-1:0] FMT_FX_4_X = FMT_W'(2);

  localparam logic MODE_LOAD = 1'b0;

  // Bits that survive narrowing to the stored format: the sign plus N_STO_PARAMS-1
  // magnitude bits whose top sits at Q_COMP+f-2. Comparing under this mask is the
  // same as comparing the narrowed words.
  function automatic logic [DATA_W-1:0] stored_mask(input logic [FMT_W-1:0] fmt);
    int                f;
    logic [DATA_W-1:0] ones;
    case (fmt)
      FMT_FX_2_X: f = 2;
      FMT_FX_3_X: f = 3;
      FMT_FX_4_X: f = 4;
      default:    f = 4;
    endcase
    ones = {DATA_W{1'b1}} >> (DATA_W - (N_STO_PARAMS - 1));
    return (ones << (Q_COMP - N_STO_PARAMS + f)) | {1'b1, {(DATA_W-1){1'b0}}};
  endfunction

  logic [1:0]            state_r;
  logic                  mode_r;
  logic [ADDR_W-1:0]     base_r;
  logic [ADDR_W:0]       len_r;
  logic [FMT_W-1:0]      format_r;
  logic [ADDR_W:0]       count_r;
  logic                  s_ready_r;
  logic                  wr_en_r;
  logic [ADDR_W-1:0]     wr_addr_r;
  logic [DATA_W-1:0]     wr_data_r;
  logic [DATA_W-1:0]     exp_r;
  logic                  cmp_valid_r;
  logic                  done_r;
  logic                  err_range_r;
  logic [MISMATCH_W-1:0] mismatch_r;

  logic                  hs_s;
  logic [ADDR_W-1:0]     addr_s;
  logic [ADDR_W+1:0]     end_s;
  logic                  range_bad_s;
  logic                  mismatch_s;

  assign hs_s        = s_valid & s_ready_r;
  assign addr_s      = base_r + count_r[ADDR_W-1:0];
  assign end_s       = (ADDR_W+2)'(base_addr) + (ADDR_W+2)'(len);
  assign range_bad_s = end_s > (ADDR_W+2)'(DEPTH);
  assign mismatch_s  = cmp_valid_r & (|((rd_data ^ exp_r) & stored_mask(format_r)));

  // Command FSM, stream counter, write pipeline stage and compare bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= 1'b0;
      base_r      <= '0;
      len_r       <= '0;
      format_r    <= '0;
      count_r     <= '0;
      s_ready_r   <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      exp_r       <= '0;
      cmp_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_range_r <= 1'b0;
      mismatch_r  <= '0;
    end else begin
      done_r      <= 1'b0;
      wr_en_r     <= 1'b0;
      cmp_valid_r <= 1'b0;
      if (mismatch_s && (mismatch_r != {MISMATCH_W{1'b1}})) begin
        mismatch_r <= mismatch_r + MISMATCH_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r      <= mode;
            base_r      <= base_addr;
            len_r       <= len;
            format_r    <= format;
            err_range_r <= range_bad_s;
            mismatch_r  <= '0;
            count_r     <= '0;
            if (range_bad_s || (len == '0)) begin
              done_r <= 1'b1;
            end else begin
              state_r   <= ST_RUN;
              s_ready_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            count_r <= count_r + (ADDR_W+1)'(1);
            if (mode_r == MODE_LOAD) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= addr_s;
              wr_data_r <= s_data;
            end else begin
              exp_r       <= s_data;
              cmp_valid_r <= 1'b1;
            end
            if ((count_r + (ADDR_W+1)'(1)) == len_r) begin
              s_ready_r <= 1'b0;
              state_r   <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          s_ready_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads must be issued in the handshake cycle so rd_data lines up one cycle later.
  assign rd_en        = hs_s & (mode_r != MODE_LOAD);
  assign rd_addr      = addr_s;
  assign rd_format    = format_r;
  assign s_ready      = s_ready_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign wr_format    = format_r;
  assign busy         = (state_r != ST_IDLE);
  assign wr_chip_en   = busy;
  assign done         = done_r;
  assign err_range    = err_range_r;
  assign mismatch_cnt = mismatch_r;

endmodule
